uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the `tx` line produced by `uart_tx` and rebuilds each frame into a parallel byte. The frame is a start bit (0), 8 data bits LSB first, an optional parity bit, and a stop bit (1). It checks parity and framing, then hands the byte downstream over a valid/ready handshake with overrun detection. It shares the transmitter's clock. It uses the same parity convention and the same `parity_en`/`even_parity` configuration as the transmitter.

## Interface
- `CLKS_PER_BIT`, 1, clock cycles per serial bit. Legal values are 1 or ≥2. A value of 1 matches `uart_tx`, which sends one bit per clock.
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `rx`  in  1  serial line; idles high; same clock domain as the transmitter, so no synchronizer
- `parity_en`  in  1  1 = a parity bit follows the data bits
- `even_parity`  in  1  parity select; expected parity bit = `even_parity ? ~^data : ^data`
- `data_out`  out  8  received byte
- `rx_valid`  out  1  `data_out` and the error flags are valid; held until accepted
- `rx_ready`  in  1  downstream accepts when `rx_valid && rx_ready` at a rising edge
- `parity_err`  out  1  parity mismatch for the byte currently on `data_out`
- `frame_err`  out  1  stop bit sampled 0 for the byte currently on `data_out`
- `overrun`  out  1  sticky; a frame completed while `rx_valid` was still high
- `rx_busy`  out  1  high in every state except IDLE

## Operation
States: BREAK, IDLE, START, DATA, PARITY, STOP.

- **BREAK**
  - Entered on reset and after a frame error.
  - Moves to IDLE on the first cycle with `rx`=1.
  - No start bit is detected here.
- **IDLE**
  - `rx`=0 at an edge counts as start-bit detection.
  - `parity_en` and `even_parity` are latched at detection and used for the whole frame. Changes mid-frame are ignored.
- **START**
  - With N=1: the detection edge is the start-bit sample, so the FSM goes straight to DATA.
  - With N≥2:
    - Wait `N/2` (floor) cycles to reach mid-bit, then resample `rx`.
    - If `rx`=1, it was a false start: return to IDLE and report nothing.
    - If `rx`=0, go to DATA.
  - After START, the bit counter samples every N cycles at mid-bit.
- **DATA**
  - 8 samples shifted in LSB first. A 3-bit counter wraps 7→0 on exit.
  - Next state is PARITY if the latched `parity_en`=1, otherwise STOP.
- **PARITY**
  - One sample.
  - `parity_err` = sample ≠ expected parity.
- **STOP**
  - One sample.
  - At that same edge, the frame result is written into the output registers:
    - `data_out` ← assembled byte
    - `parity_err` ← PARITY result (0 when parity is disabled)
    - `frame_err` ← (stop sample = 0)
    - `rx_valid` ← 1
  - Next state: IDLE if stop = 1, BREAK if stop = 0.
- **Handshake**
  - `rx_valid` clears on the edge where `rx_valid && rx_ready`.
  - If STOP completes while `rx_valid` is still high and not being accepted that same edge:
    - `overrun` is set.
    - The new frame is discarded; `data_out` and the error flags keep the old byte.
  - If acceptance and completion fall on the same edge, the new frame is loaded and `rx_valid` stays 1. This is not an overrun.
  - `overrun` clears only on reset.

## Timing
- **Reset** (`rst_n`=0 at a rising edge): state becomes BREAK. The following are all 0:
  - `data_out`=0x00
  - `rx_valid`
  - `parity_err`, `frame_err`, `overrun`
  - `rx_busy`
  - Reset mid-frame abandons the partial byte. No output is produced for it.
- **Latency (N=1)**: start detected at edge k. Data bit i is sampled at edge k+1+i. Parity is sampled at k+9. Stop is sampled at k+10 with parity, or k+9 without. `rx_valid` is visible after the stop edge.
- **Latency (N≥2)**: bit j (start = 0) is sampled at edge k + N/2 + j·N.
- **Back-to-back frames**: at N=1, a start bit on the cycle right after the stop bit must be accepted. IDLE detection occurs on the first cycle in IDLE.
- **`rx_busy`**: rises the edge after detection and falls the edge after the stop sample.

## Test plan
- N=1, parity off, 0xA5 sent (bit sequence 0,1,0,1,0,0,1,0,1,1), `rx_ready`=1 → `data_out`=0xA5; `rx_valid` high for 1 cycle; no error flags.
- N=1, parity on, byte 0xA5:
  - `even_parity`=1 with parity bit 1 → no error.
  - Same frame with parity bit 0 → `parity_err`=1; `data_out`=0xA5.
- N=1, 0x3C with stop bit 0, then `rx` held low 5 cycles → `frame_err`=1 and `rx_valid`=1; no new frame while low. After `rx` goes high, a following 0x81 frame is received cleanly.
- `rx_ready`=0, frames 0x11 then 0x22 → `data_out` stays 0x11; `overrun`=1. Raising `rx_ready` clears `rx_valid`; `overrun` stays 1 until reset.
- N=4:
  - 1-cycle low glitch on `rx` → no `rx_valid`; `rx_busy` falls back to 0.
  - Then a full 0x5A frame → `data_out`=0x5A.
- Reset asserted at data bit 4 of 0xFF, `rx` driven high afterwards → all outputs 0 the next cycle. A following 0x0F frame is received as 0x0F.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 8-bit frames (start, 8 data LSB first,
// optional parity, stop) with parity/framing checks and a valid/ready
// output handshake with sticky overrun detection.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   rx                  serial line, idles high, same clock domain as sender
//   parity_en           1 = parity bit follows data (latched per frame)
//   even_parity         parity select (latched per frame)
//   data_out            received byte
//   rx_valid            data_out and error flags valid, held until accepted
//   rx_ready            downstream accept
//   parity_err          parity mismatch for byte on data_out
//   frame_err           stop bit sampled 0 for byte on data_out
//   overrun             sticky, frame completed while rx_valid pending
//   rx_busy             high in every state except IDLE
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       even_parity,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_MAX  = CLKS_PER_BIT - 1;
  localparam int unsigned HALF_MAX = (CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2) - 1 : 0;

  typedef enum logic [2:0] {
    ST_BREAK  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_en_q, par_en_d;
  logic               even_q, even_d;
  logic               frame_perr_q, frame_perr_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;

  logic               tick;
  logic               half_tick;
  logic               accept;
  logic               exp_par;

  // Bit-period timing: tick marks a mid-bit sample once aligned by START.
  assign tick      = (cnt_q == CNT_W'(BIT_MAX));
  assign half_tick = (cnt_q == CNT_W'(HALF_MAX));
  assign accept    = valid_q & rx_ready;
  assign exp_par   = even_q ? ~^shift_q : ^shift_q;

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    even_d       = even_q;
    frame_perr_d = frame_perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    busy_d       = (state_q != ST_IDLE);

    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_BREAK: begin
        // Line must return high before any start bit is honoured.
        if (rx) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!rx) begin
          par_en_d     = parity_en;
          even_d       = even_parity;
          frame_perr_d = 1'b0;
          cnt_d        = '0;
          bit_d        = 3'd0;
          // At one clock per bit the detection edge is the start sample.
          if (CLKS_PER_BIT == 1) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        if (half_tick) begin
          cnt_d   = '0;
          state_d = rx ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (tick) begin
          cnt_d        = '0;
          frame_perr_d = (rx != exp_par);
          state_d      = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (tick) begin
          cnt_d = '0;
          // Load only if the output slot is free or being freed this edge.
          if (!valid_q || accept) begin
            data_d  = shift_q;
            perr_d  = frame_perr_q;
            ferr_d  = ~rx;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = rx ? ST_IDLE : ST_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_BREAK;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BREAK;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      par_en_q     <= 1'b0;
      even_q       <= 1'b0;
      frame_perr_q <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      even_q       <= even_d;
      frame_perr_q <= frame_perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at one clock per bit and at
// four clocks per bit.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       rx1, pen1, ev1, rdy1;
  logic [7:0] dout1;
  logic       vld1, perr1, ferr1, ovr1, busy1;

  logic       rx4, pen4, ev4, rdy4;
  logic [7:0] dout4;
  logic       vld4, perr4, ferr4, ovr4, busy4;

  int   tests;
  int   fails;
  exp_t q1[$];
  exp_t q4[$];
  exp_t m1;
  exp_t m4;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .parity_en(pen1), .even_parity(ev1),
    .data_out(dout1), .rx_valid(vld1), .rx_ready(rdy1), .parity_err(perr1),
    .frame_err(ferr1), .overrun(ovr1), .rx_busy(busy1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4), .parity_en(pen4), .even_parity(ev4),
    .data_out(dout4), .rx_valid(vld4), .rx_ready(rdy4), .parity_err(perr4),
    .frame_err(ferr4), .overrun(ovr4), .rx_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pop and compare whenever an accept will happen at the coming edge.
  always @(negedge clk) begin
    if (rst_n && vld1 && rdy1) begin
      if (q1.size() == 0) begin
        chk("n1_unexpected_valid", 32'(1), 32'(0));
      end else begin
        m1 = q1.pop_front();
        chk("n1_data", 32'(dout1), 32'(m1.d));
        chk("n1_perr", 32'(perr1), 32'(m1.pe));
        chk("n1_ferr", 32'(ferr1), 32'(m1.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld4 && rdy4) begin
      if (q4.size() == 0) begin
        chk("n4_unexpected_valid", 32'(1), 32'(0));
      end else begin
        m4 = q4.pop_front();
        chk("n4_data", 32'(dout4), 32'(m4.d));
        chk("n4_perr", 32'(perr4), 32'(m4.pe));
        chk("n4_ferr", 32'(ferr4), 32'(m4.fe));
      end
    end
  end

  // Called at posedge+1; holds one serial bit for the DUT's bit period.
  task automatic drive_bit(input int which, input logic b);
    if (which == 1) begin
      rx1 = b;
      @(posedge clk);
    end else begin
      rx4 = b;
      repeat (4) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pen,
                            input logic ev, input logic bad_par, input logic stop,
                            input logic push);
    logic p;
    exp_t e;
    p = ev ? ~^d : ^d;
    if (bad_par) p = ~p;
    e.d  = d;
    e.pe = pen & bad_par;
    e.fe = ~stop;
    if (which == 1) begin
      pen1 = pen;
      ev1  = ev;
      if (push) q1.push_back(e);
    end else begin
      pen4 = pen;
      ev4  = ev;
      if (push) q4.push_back(e);
    end
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (pen) drive_bit(which, p);
    drive_bit(which, stop);
  endtask

  task automatic wait_drain(input int which);
    int n;
    n = 0;
    if (which == 1) begin
      while (n < 200 && q1.size() != 0) begin
        @(posedge clk); #1; n++;
      end
      chk("n1_drain_timeout", 32'(q1.size()), 32'(0));
    end else begin
      while (n < 200 && q4.size() != 0) begin
        @(posedge clk); #1; n++;
      end
      chk("n4_drain_timeout", 32'(q4.size()), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    rx1 = 1'b1; pen1 = 1'b0; ev1 = 1'b0; rdy1 = 1'b1;
    rx4 = 1'b1; pen4 = 1'b0; ev4 = 1'b0; rdy4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data1",  32'(dout1), 32'(0));
    chk("rst_valid1", 32'(vld1),  32'(0));
    chk("rst_perr1",  32'(perr1), 32'(0));
    chk("rst_ferr1",  32'(ferr1), 32'(0));
    chk("rst_ovr1",   32'(ovr1),  32'(0));
    chk("rst_busy1",  32'(busy1), 32'(0));
    chk("rst_valid4", 32'(vld4),  32'(0));
    chk("rst_busy4",  32'(busy4), 32'(0));
    rst_n = 1'b1;
    repeat (3) drive_bit(1, 1'b1);

    // Parity off, then back-to-back frames with no idle gap.
    send_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1, 1'b1);
    wait_drain(1);
    drive_bit(1, 1'b1);
    chk("n1_valid_one_cycle", 32'(vld1), 32'(0));

    // Parity on: good even, bad even, good odd.
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1, 1'b1);
    wait_drain(1);

    // Framing error, line held low: no new frame until it returns high.
    send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) drive_bit(1, 1'b0);
    chk("n1_break_busy", 32'(busy1), 32'(1));
    chk("n1_break_no_frame", 32'(q1.size()), 32'(0));
    repeat (2) drive_bit(1, 1'b1);
    send_frame(1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1, 1'b1);
    wait_drain(1);

    // Overrun: second frame discarded while the first is pending.
    rdy1 = 1'b0;
    send_frame(1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) drive_bit(1, 1'b1);
    chk("ovr_data_kept", 32'(dout1), 32'h11);
    chk("ovr_valid_held", 32'(vld1), 32'(1));
    chk("ovr_flag", 32'(ovr1), 32'(1));
    rdy1 = 1'b1;
    wait_drain(1);
    drive_bit(1, 1'b1);
    chk("ovr_valid_cleared", 32'(vld1), 32'(0));
    chk("ovr_sticky", 32'(ovr1), 32'(1));

    // N=4: a one-cycle glitch is a false start.
    rx4 = 1'b0;
    @(posedge clk); #1;
    rx4 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("n4_glitch_busy", 32'(busy4), 32'(0));
    chk("n4_glitch_valid", 32'(vld4), 32'(0));
    send_frame(4, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(4, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(4, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_bit(4, 1'b1);
    wait_drain(4);

    // Reset in the middle of data bit 4 of 0xFF.
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, 1'b1);
    rst_n = 1'b0;
    rx1   = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_data", 32'(dout1), 32'(0));
    chk("mid_rst_valid", 32'(vld1), 32'(0));
    chk("mid_rst_ferr", 32'(ferr1), 32'(0));
    chk("mid_rst_perr", 32'(perr1), 32'(0));
    chk("mid_rst_ovr", 32'(ovr1), 32'(0));
    chk("mid_rst_busy", 32'(busy1), 32'(0));
    rst_n = 1'b1;
    repeat (3) drive_bit(1, 1'b1);
    send_frame(1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1, 1'b1);
    wait_drain(1);
    repeat (3) drive_bit(1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
